data_mem_lsu: RTL
=================

# data_mem_lsu

Load/store unit between the CPU datapath and the word-organised Harvard data RAM. Accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests, converts them to word-addressed RAM accesses, sign- or zero-extends load data, and performs read-modify-write for sub-word stores because the RAM writes only whole words. It stalls the CPU through a busy/done handshake.

## Interface
- `MISALIGN_ERR_RDATA`, default 32'h0000_0000: value returned on `cpu_rdata` for a trapped request.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_valid` in 1: request strobe; sampled only in IDLE.
- `cpu_op` in 3: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data; the byte/halfword is taken from the low bits.
- `cpu_busy` out 1: high whenever state ≠ IDLE.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: load result; valid while `cpu_done`=1, held until the next completion.
- `cpu_err` out 1: misaligned trap flag, valid with `cpu_done`.
- `mem_address` out 32: word address = {2'b00, addr[31:2]}.
- `mem_writedata` out 32: full word to RAM; 0 when `mem_write_en`=0.
- `mem_readdata` in 32: combinational RAM read data.
- `mem_write_en` out 1: RAM write strobe.
- `mem_read_en` out 1: RAM read strobe.

## Operation
- Byte lanes are little-endian: byte k of a word occupies bits [8k+7:8k]; halfword h occupies bits [16h+15:16h].
- States: IDLE, RD, WR, DONE.
- IDLE: when `cpu_valid`=1, latch op, addr, and wdata. Then go to:
  - RD for any load, SB, or SH;
  - WR for SW;
  - DONE with err=1 for a trapped misaligned request.
- RD: `mem_read_en`=1. Capture `mem_readdata` at the clock edge.
  - Loads → DONE, with the extracted lane sign-extended (LB/LH) or zero-extended (LBU/LHU). LW returns the word unchanged.
  - SB/SH → WR.
- WR: `mem_write_en`=1.
  - SW writes the latched wdata.
  - SB/SH write the captured word with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
  - → DONE.
- DONE: `cpu_done`=1 → IDLE. `cpu_valid` is ignored in DONE.
- `mem_read_en` and `mem_write_en` are never high in the same cycle, and are never high in IDLE or DONE.
- Stores never update `cpu_rdata`. It keeps its previous value, `cpu_done` still pulses, and err=0.
- Reset mid-operation:
  - the FSM returns to IDLE on that edge;
  - `mem_write_en` is gated by `!reset`, so no RAM write occurs in a reset cycle;
  - the aborted request is dropped with no `cpu_done`.

## Timing
- Reset values:
  - state IDLE;
  - `cpu_busy`, `cpu_done`, `cpu_err`, `mem_read_en`, `mem_write_en` = 0;
  - `cpu_rdata`, `mem_address`, `mem_writedata` = 0.
- With the request accepted at edge T (`cpu_valid` high in IDLE):
  - Load: RD during cycle T+1; `cpu_done` during T+2. Latency is 2 cycles.
  - SW: WR during T+1; `cpu_done` during T+2.
  - SB/SH: RD during T+1, WR during T+2; `cpu_done` during T+3.
  - Trapped request: `cpu_done`+`cpu_err` during T+1.
- Minimum spacing between accepted requests: the next request is accepted at the edge ending the cycle after DONE. Back-to-back loads therefore complete every 3 cycles.
- `mem_address` is registered from the latched address and is stable for every cycle the FSM is outside IDLE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issues no RAM access;
  - completes with `cpu_err`=1 and `cpu_rdata`=`MISALIGN_ERR_RDATA`.
- Not defined:
  - `cpu_err` is tied 0;
  - halfword ops ignore addr[0] and word ops ignore addr[1:0], so the access is forced aligned;
  - `MISALIGN_ERR_RDATA` is unused.

## Test plan
- RAM word 4 = 32'h8899_AABB. LB from addr 0x12 → rdata 32'hFFFF_FF99 at T+2; LBU from addr 0x12 → 32'h0000_0099.
- Same word. LH from addr 0x10 → 32'hFFFF_AABB; LHU from addr 0x12 → 32'h0000_8899; LW from addr 0x10 → 32'h8899_AABB.
- SB wdata 32'h1234_5677 to addr 0x11 over RAM word 4 = 32'h8899_AABB:
  - write at T+2 of 32'h8899_77BB;
  - `cpu_done` at T+3;
  - exactly one read and one write strobe.
- SW 32'hDEAD_BEEF to addr 0x20 → `mem_address`=8 and write at T+1, no read strobe; `cpu_done` at T+2.
- LW to addr 0x22:
  - with `LSU_MISALIGN_TRAP_EN`: `cpu_done`+`cpu_err` at T+1, rdata=0, no strobes;
  - without it: returns word 8.
- SH accepted, `reset` asserted during the WR cycle → no write to the RAM, FSM in IDLE next cycle, all outputs at reset values, no `cpu_done`.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Load/store unit: byte-addressed CPU requests to a word-wide data RAM, with
// read-modify-write for sub-word stores. Optional trap: LSU_MISALIGN_TRAP_EN.
module data_mem_lsu #(
   parameter logic [31:0] MISALIGN_ERR_RDATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_valid,
   input  logic [2:0]  cpu_op,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_busy,
   output logic        cpu_done,
   output logic [31:0] cpu_rdata,
   output logic        cpu_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   output logic        mem_write_en,
   output logic        mem_read_en
);

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LW  = 3'd2;
   localparam logic [2:0] OP_LBU = 3'd3;
   localparam logic [2:0] OP_LHU = 3'd4;
   localparam logic [2:0] OP_SB  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t      state_reg, state_next;
   logic [2:0]  op_reg;
   logic [1:0]  lane_reg;
   logic [31:0] wdata_reg;
   logic [31:0] word_reg;
   logic [31:0] rdata_reg;
   logic [31:0] maddr_reg;
   logic        err_reg;

   logic        trap_req;
   logic        op_is_load;
   logic        op_is_rmw;
   logic [31:0] load_val;
   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic [3:0]  byte_en;
   logic [31:0] lane_data;
   logic [31:0] merged_word;

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      trap_req = 1'b0;
      case (cpu_op)
         OP_LH, OP_LHU, OP_SH: trap_req = cpu_addr[0];
         OP_LW, OP_SW:         trap_req = |cpu_addr[1:0];
         default:              trap_req = 1'b0;
      endcase
   end
`else
   assign trap_req = 1'b0;
`endif

   assign op_is_load = (op_reg <= OP_LHU);
   assign op_is_rmw  = (op_reg == OP_SB) || (op_reg == OP_SH);

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (cpu_valid) begin
               if (trap_req)
                  state_next = DONE;
               else if (cpu_op == OP_SW)
                  state_next = WR;
               else
                  state_next = RD;
            end
         end
         RD:      state_next = op_is_rmw ? WR : DONE;
         WR:      state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Halfword lane uses only addr[1], so unaligned halfwords fall back to aligned
   always_comb begin
      byte_val = mem_readdata[8*lane_reg +: 8];
      half_val = lane_reg[1] ? mem_readdata[31:16] : mem_readdata[15:0];
      load_val = mem_readdata;
      case (op_reg)
         OP_LB:   load_val = {{24{byte_val[7]}}, byte_val};
         OP_LH:   load_val = {{16{half_val[15]}}, half_val};
         OP_LBU:  load_val = {24'h0, byte_val};
         OP_LHU:  load_val = {16'h0, half_val};
         default: load_val = mem_readdata;
      endcase
   end

   always_comb begin
      byte_en   = 4'b1111;
      lane_data = wdata_reg;
      case (op_reg)
         OP_SB: begin
            byte_en   = 4'b0001 << lane_reg;
            lane_data = {4{wdata_reg[7:0]}};
         end
         OP_SH: begin
            byte_en   = lane_reg[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_reg[15:0]}};
         end
         default: begin
            byte_en   = 4'b1111;
            lane_data = wdata_reg;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_merge
         assign merged_word[8*gi +: 8] = byte_en[gi] ? lane_data[8*gi +: 8]
                                                     : word_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         op_reg    <= OP_LB;
         lane_reg  <= 2'b00;
         wdata_reg <= 32'h0;
         word_reg  <= 32'h0;
         rdata_reg <= 32'h0;
         maddr_reg <= 32'h0;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cpu_valid) begin
                  op_reg    <= cpu_op;
                  lane_reg  <= cpu_addr[1:0];
                  wdata_reg <= cpu_wdata;
                  maddr_reg <= {2'b00, cpu_addr[31:2]};
                  err_reg   <= trap_req;
                  if (trap_req)
                     rdata_reg <= MISALIGN_ERR_RDATA;
               end
            end
            RD: begin
               word_reg <= mem_readdata;
               // Stores leave the previous load result visible
               if (op_is_load)
                  rdata_reg <= load_val;
            end
            default: ;
         endcase
      end
   end

   assign cpu_busy      = (state_reg != IDLE);
   assign cpu_done      = (state_reg == DONE);
   assign cpu_err       = cpu_done && err_reg;
   assign cpu_rdata     = rdata_reg;
   assign mem_address   = maddr_reg;
   assign mem_read_en   = (state_reg == RD);
   assign mem_write_en  = (state_reg == WR) && !reset;
   assign mem_writedata = mem_write_en ? merged_word : 32'h0;

endmodule
